// File: rtl/lab5_mcore_imul_arbiter_if.sv
// Core-side and multiplier-side val/rdy channels of the shared imul arbiter.
// slave is the arbiter's view; master is the view of the cores plus the multiplier.
interface lab5_mcore_imul_arbiter_if #(
    parameter int p_num_reqs   = 4,
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
);
    logic [p_num_reqs-1:0]             in_req_val;
    logic [p_num_reqs-1:0]             in_req_rdy;
    logic [p_num_reqs*p_req_nbits-1:0] in_req_msg;
    logic [p_num_reqs-1:0]             out_resp_val;
    logic [p_num_reqs-1:0]             out_resp_rdy;
    logic [p_resp_nbits-1:0]           out_resp_msg;
    logic                              unit_req_val;
    logic                              unit_req_rdy;
    logic [p_req_nbits-1:0]            unit_req_msg;
    logic                              unit_resp_val;
    logic                              unit_resp_rdy;
    logic [p_resp_nbits-1:0]           unit_resp_msg;

    modport slave (
        input  in_req_val, in_req_msg, out_resp_rdy,
        input  unit_req_rdy, unit_resp_val, unit_resp_msg,
        output in_req_rdy, out_resp_val, out_resp_msg,
        output unit_req_val, unit_req_msg, unit_resp_rdy
    );

    modport master (
        output in_req_val, in_req_msg, out_resp_rdy,
        output unit_req_rdy, unit_resp_val, unit_resp_msg,
        input  in_req_rdy, out_resp_val, out_resp_msg,
        input  unit_req_val, unit_req_msg, unit_resp_rdy
    );
endinterface

// File: rtl/lab5_mcore_imul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among p_num_reqs cores, one op in flight.
// Define LAB5_MCORE_IMUL_ARB_STATS_EN to add saturating grant / wait-cycle counters.
module lab5_mcore_imul_arbiter #(
    parameter int p_num_reqs   = 4,
    parameter int p_req_nbits  = 64,
    parameter int p_resp_nbits = 32
) (
    input  logic clk,
    input  logic reset,
    lab5_mcore_imul_arbiter_if.slave bus
`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
    ,
    input  logic        stats_clear,
    output logic [31:0] stats_grants,
    output logic [31:0] stats_wait_cycles
`endif
);

    localparam int IDX_W  = $clog2(p_num_reqs);
    localparam int IDX_W1 = IDX_W + 1;
    localparam logic [IDX_W:0]   NUM  = IDX_W1'(p_num_reqs);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(p_num_reqs - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t fsm, fsm_next;
    logic [IDX_W-1:0] owner, owner_next;
    logic [IDX_W-1:0] prio_ptr, prio_next;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic [IDX_W:0]   idx;
    logic             found;

    logic [p_num_reqs-1:0]   req_rdy;
    logic [p_num_reqs-1:0]   resp_val;
    logic [p_resp_nbits-1:0] resp_msg;
    logic                    ureq_val;
    logic [p_req_nbits-1:0]  ureq_msg;
    logic                    uresp_rdy;
    logic [p_req_nbits-1:0]  sel_msg;

    // Rotating-priority scan starting at prio_ptr, wrapping modulo p_num_reqs.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            idx = {1'b0, prio_ptr} + IDX_W1'(k);
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (!found && bus.in_req_val[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

    // Once a request has stalled the grant is frozen so the offered message cannot change.
    assign sel     = (fsm == HOLD) ? owner : winner;
    assign sel_msg = bus.in_req_msg[int'(sel)*p_req_nbits +: p_req_nbits];

    always_comb begin
        fsm_next   = fsm;
        owner_next = owner;
        prio_next  = prio_ptr;
        req_rdy    = '0;
        resp_val   = '0;
        resp_msg   = '0;
        ureq_val   = 1'b0;
        ureq_msg   = '0;
        uresp_rdy  = 1'b0;
        case (fsm)
            IDLE: begin
                ureq_val = found;
                if (found) begin
                    ureq_msg        = sel_msg;
                    req_rdy[winner] = bus.unit_req_rdy;
                    owner_next      = winner;
                    fsm_next        = bus.unit_req_rdy ? BUSY : HOLD;
                end
            end
            HOLD: begin
                ureq_val       = bus.in_req_val[owner];
                ureq_msg       = sel_msg;
                req_rdy[owner] = bus.unit_req_rdy;
                if (!bus.in_req_val[owner]) begin
                    fsm_next = IDLE;
                end else if (bus.unit_req_rdy) begin
                    fsm_next = BUSY;
                end
            end
            BUSY: begin
                resp_val[owner] = bus.unit_resp_val;
                resp_msg        = bus.unit_resp_msg;
                uresp_rdy       = bus.out_resp_rdy[owner];
                if (bus.unit_resp_val && bus.out_resp_rdy[owner]) begin
                    prio_next = (owner == LAST) ? '0 : owner + 1'b1;
                    fsm_next  = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm      <= IDLE;
            owner    <= '0;
            prio_ptr <= '0;
        end else begin
            fsm      <= fsm_next;
            owner    <= owner_next;
            prio_ptr <= prio_next;
        end
    end

    // The arbiter is silent while reset is held, whatever the inputs are doing.
    assign bus.in_req_rdy    = reset ? req_rdy   : '0;
    assign bus.out_resp_val  = reset ? resp_val  : '0;
    assign bus.out_resp_msg  = reset ? resp_msg  : '0;
    assign bus.unit_req_val  = reset ? ureq_val  : 1'b0;
    assign bus.unit_req_msg  = reset ? ureq_msg  : '0;
    assign bus.unit_resp_rdy = reset ? uresp_rdy : 1'b0;

`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
    logic req_fire;
    logic waiting;

    assign req_fire = ureq_val && bus.unit_req_rdy;
    assign waiting  = |(bus.in_req_val & ~req_rdy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stats_grants      <= '0;
            stats_wait_cycles <= '0;
        end else if (stats_clear) begin
            stats_grants      <= '0;
            stats_wait_cycles <= '0;
        end else begin
            if (req_fire && (stats_grants != 32'hFFFF_FFFF)) begin
                stats_grants <= stats_grants + 32'd1;
            end
            if (waiting && (stats_wait_cycles != 32'hFFFF_FFFF)) begin
                stats_wait_cycles <= stats_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lab5_mcore_imul_arbiter.sv
// Directed bench for lab5_mcore_imul_arbiter with a behavioural 3-cycle multiplier.
// Build with LAB5_MCORE_IMUL_ARB_STATS_EN to also exercise the counters.
module tb_lab5_mcore_imul_arbiter;

    localparam int N      = 4;
    localparam int REQ_W  = 64;
    localparam int RESP_W = 32;
    localparam int LAT    = 3;
    localparam int BUDGET = 40;

    logic clk;
    logic reset;
    logic mul_stall;
    int   errors = 0;
    int   checks = 0;

    lab5_mcore_imul_arbiter_if #(
        .p_num_reqs(N), .p_req_nbits(REQ_W), .p_resp_nbits(RESP_W)
    ) bus ();

`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
    logic        stats_clear;
    logic [31:0] stats_grants;
    logic [31:0] stats_wait_cycles;
`endif

    lab5_mcore_imul_arbiter #(
        .p_num_reqs(N), .p_req_nbits(REQ_W), .p_resp_nbits(RESP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
        ,
        .stats_clear(stats_clear),
        .stats_grants(stats_grants),
        .stats_wait_cycles(stats_wait_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier stand-in: accepts when idle, answers LAT cycles later, shares the arbiter reset.
    logic        mul_busy;
    logic [3:0]  mul_cnt;
    logic [31:0] mul_res;

    assign bus.unit_req_rdy  = !mul_busy && !mul_stall;
    assign bus.unit_resp_val = mul_busy && (mul_cnt == 4'd0);
    assign bus.unit_resp_msg = (mul_busy && (mul_cnt == 4'd0)) ? mul_res : 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy <= 1'b0;
            mul_cnt  <= 4'd0;
            mul_res  <= 32'h0;
        end else if (!mul_busy) begin
            if (bus.unit_req_val && bus.unit_req_rdy) begin
                mul_busy <= 1'b1;
                mul_cnt  <= 4'(LAT);
                mul_res  <= bus.unit_req_msg[63:32] * bus.unit_req_msg[31:0];
            end
        end else if (mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
        end else if (bus.unit_resp_rdy) begin
            mul_busy <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.in_req_msg[i*REQ_W +: REQ_W] = {a, b};
    endtask

    task automatic wait_resp(output bit ok);
        int n = 0;
        ok = (bus.out_resp_val != '0);
        while (!ok && n < BUDGET) begin
            step();
            #1;
            n++;
            ok = (bus.out_resp_val != '0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL resp_timeout: got no response, expected one within %0d cycles", BUDGET);
        end
    endtask

    task automatic test_reset();
        logic [1:0] st;
        set_req(0, 32'h1234, 32'h5678);
        set_req(2, 32'h9abc, 32'hdef0);
        bus.in_req_val = 4'hF;
        step();
        #1;
        st = dut.fsm;
        checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL rst_in_req_rdy: got %b expected 0000", bus.in_req_rdy); end
        checks++; if (bus.out_resp_val !== 4'b0000) begin errors++; $display("[TB] FAIL rst_out_resp_val: got %b expected 0000", bus.out_resp_val); end
        checks++; if (bus.unit_req_val !== 1'b0) begin errors++; $display("[TB] FAIL rst_unit_req_val: got %b expected 0", bus.unit_req_val); end
        checks++; if (bus.unit_resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_unit_resp_rdy: got %b expected 0", bus.unit_resp_rdy); end
        checks++; if (bus.unit_req_msg !== 64'h0) begin errors++; $display("[TB] FAIL rst_unit_req_msg: got %h expected 0", bus.unit_req_msg); end
        checks++; if (st !== 2'd0) begin errors++; $display("[TB] FAIL rst_fsm: got %0d expected 0 (IDLE)", st); end
        checks++; if (dut.prio_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rst_prio_ptr: got %0d expected 0", dut.prio_ptr); end
        checks++; if (dut.owner !== 2'd0) begin errors++; $display("[TB] FAIL rst_owner: got %0d expected 0", dut.owner); end
        bus.in_req_val = 4'h0;
        step();
        reset = 1'b1;
        #1;
        checks++; if (bus.unit_req_val !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_idle: got unit_req_val=%b expected 0", bus.unit_req_val); end
    endtask

    task automatic test_grant_freeze();
        bit ok;
        mul_stall = 1'b1;
        set_req(2, 32'd10, 32'd11);
        set_req(0, 32'd12, 32'd13);
        bus.in_req_val = 4'b0100;
        #1;
        checks++; if (bus.unit_req_msg !== {32'd10, 32'd11}) begin errors++; $display("[TB] FAIL freeze_c0_msg: got %h expected %h", bus.unit_req_msg, {32'd10, 32'd11}); end
        checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL freeze_c0_rdy: got %b expected 0000", bus.in_req_rdy); end
        step();
        bus.in_req_val = 4'b0101;
        #1;
        checks++; if (bus.unit_req_msg !== {32'd10, 32'd11}) begin errors++; $display("[TB] FAIL freeze_c1_msg: got %h expected %h", bus.unit_req_msg, {32'd10, 32'd11}); end
        checks++; if (bus.unit_req_val !== 1'b1) begin errors++; $display("[TB] FAIL freeze_c1_val: got %b expected 1", bus.unit_req_val); end
        step();
        #1;
        checks++; if (bus.unit_req_msg !== {32'd10, 32'd11}) begin errors++; $display("[TB] FAIL freeze_c2_msg: got %h expected %h", bus.unit_req_msg, {32'd10, 32'd11}); end
        mul_stall = 1'b0;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0100) begin errors++; $display("[TB] FAIL freeze_fire_rdy: got %b expected 0100", bus.in_req_rdy); end
        checks++; if (bus.unit_req_msg !== {32'd10, 32'd11}) begin errors++; $display("[TB] FAIL freeze_fire_msg: got %h expected %h", bus.unit_req_msg, {32'd10, 32'd11}); end
        step();
        bus.in_req_val = 4'b0001;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL freeze_busy_rdy: got %b expected 0000", bus.in_req_rdy); end
        wait_resp(ok);
        checks++; if (bus.out_resp_val !== 4'b0100) begin errors++; $display("[TB] FAIL freeze_resp_val: got %b expected 0100", bus.out_resp_val); end
        checks++; if (bus.out_resp_msg !== 32'd110) begin errors++; $display("[TB] FAIL freeze_resp_msg: got %0d expected 110", bus.out_resp_msg); end
        step();
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0001) begin errors++; $display("[TB] FAIL freeze_next_rdy: got %b expected 0001", bus.in_req_rdy); end
        checks++; if (bus.unit_req_msg !== {32'd12, 32'd13}) begin errors++; $display("[TB] FAIL freeze_next_msg: got %h expected %h", bus.unit_req_msg, {32'd12, 32'd13}); end
        step();
        bus.in_req_val = 4'b0000;
        #1;
        wait_resp(ok);
        checks++; if (bus.out_resp_val !== 4'b0001) begin errors++; $display("[TB] FAIL freeze_next_resp_val: got %b expected 0001", bus.out_resp_val); end
        checks++; if (bus.out_resp_msg !== 32'd156) begin errors++; $display("[TB] FAIL freeze_next_resp_msg: got %0d expected 156", bus.out_resp_msg); end
        step();
        #1;
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        logic [1:0] st;
        set_req(1, 32'd5, 32'd6);
        bus.in_req_val = 4'b0010;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0010) begin errors++; $display("[TB] FAIL rmb_grant: got %b expected 0010", bus.in_req_rdy); end
        step();
        bus.in_req_val = 4'b0000;
        #1;
        step();
        #1;
        reset = 1'b0;
        #1;
        st = dut.fsm;
        checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL rmb_in_req_rdy: got %b expected 0000", bus.in_req_rdy); end
        checks++; if (bus.out_resp_val !== 4'b0000) begin errors++; $display("[TB] FAIL rmb_out_resp_val: got %b expected 0000", bus.out_resp_val); end
        checks++; if (bus.unit_req_val !== 1'b0) begin errors++; $display("[TB] FAIL rmb_unit_req_val: got %b expected 0", bus.unit_req_val); end
        checks++; if (bus.unit_resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rmb_unit_resp_rdy: got %b expected 0", bus.unit_resp_rdy); end
        checks++; if (st !== 2'd0) begin errors++; $display("[TB] FAIL rmb_fsm: got %0d expected 0 (IDLE)", st); end
        checks++; if (dut.prio_ptr !== 2'd0) begin errors++; $display("[TB] FAIL rmb_prio_ptr: got %0d expected 0", dut.prio_ptr); end
        step();
        reset = 1'b1;
        set_req(3, 32'd7, 32'd8);
        bus.in_req_val = 4'b1000;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b1000) begin errors++; $display("[TB] FAIL rmb_req3_rdy: got %b expected 1000", bus.in_req_rdy); end
        checks++; if (bus.unit_req_msg !== {32'd7, 32'd8}) begin errors++; $display("[TB] FAIL rmb_req3_msg: got %h expected %h", bus.unit_req_msg, {32'd7, 32'd8}); end
        step();
        bus.in_req_val = 4'b0000;
        #1;
        wait_resp(ok);
        checks++; if (bus.out_resp_val !== 4'b1000) begin errors++; $display("[TB] FAIL rmb_resp_val: got %b expected 1000", bus.out_resp_val); end
        checks++; if (bus.out_resp_msg !== 32'd56) begin errors++; $display("[TB] FAIL rmb_resp_msg: got %0d expected 56", bus.out_resp_msg); end
        step();
        #1;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [63:0] exp_msg [4];
        logic [31:0] exp_prod [4];
        logic [3:0]  oh;
        int          e;
        exp_msg  = '{{32'd2, 32'd3}, {32'd4, 32'd5}, {32'd6, 32'd7}, {32'd8, 32'd9}};
        exp_prod = '{32'd6, 32'd20, 32'd42, 32'd72};
        for (int i = 0; i < N; i++) begin
            set_req(i, exp_msg[i][63:32], exp_msg[i][31:0]);
        end
        bus.in_req_val = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            e  = k % 4;
            oh = 4'b0001 << e;
            checks++; if (bus.in_req_rdy !== oh) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, bus.in_req_rdy, oh); end
            checks++; if (bus.unit_req_msg !== exp_msg[e]) begin errors++; $display("[TB] FAIL rr_msg%0d: got %h expected %h", k, bus.unit_req_msg, exp_msg[e]); end
            step();
            #1;
            checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL rr_busy_rdy%0d: got %b expected 0000", k, bus.in_req_rdy); end
            wait_resp(ok);
            checks++; if (bus.out_resp_val !== oh) begin errors++; $display("[TB] FAIL rr_resp_val%0d: got %b expected %b", k, bus.out_resp_val, oh); end
            checks++; if (bus.out_resp_msg !== exp_prod[e]) begin errors++; $display("[TB] FAIL rr_resp_msg%0d: got %0d expected %0d", k, bus.out_resp_msg, exp_prod[e]); end
            step();
            #1;
        end
        bus.in_req_val = 4'h0;
        #1;
    endtask

    task automatic test_single();
        bit ok;
        set_req(1, 32'd3, 32'd7);
        bus.in_req_val = 4'b0010;
        #1;
        checks++; if (bus.unit_req_val !== 1'b1) begin errors++; $display("[TB] FAIL single_val: got %b expected 1", bus.unit_req_val); end
        checks++; if (bus.unit_req_msg !== {32'd3, 32'd7}) begin errors++; $display("[TB] FAIL single_msg: got %h expected %h", bus.unit_req_msg, {32'd3, 32'd7}); end
        checks++; if (bus.in_req_rdy !== 4'b0010) begin errors++; $display("[TB] FAIL single_rdy: got %b expected 0010", bus.in_req_rdy); end
        step();
        bus.in_req_val = 4'b0000;
        #1;
        wait_resp(ok);
        checks++; if (bus.out_resp_val !== 4'b0010) begin errors++; $display("[TB] FAIL single_resp_val: got %b expected 0010", bus.out_resp_val); end
        checks++; if (bus.out_resp_msg !== 32'd21) begin errors++; $display("[TB] FAIL single_resp_msg: got %0d expected 21", bus.out_resp_msg); end
        checks++; if (bus.unit_resp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_unit_resp_rdy: got %b expected 1", bus.unit_resp_rdy); end
        step();
        #1;
        checks++; if (dut.prio_ptr !== 2'd2) begin errors++; $display("[TB] FAIL single_prio_ptr: got %0d expected 2", dut.prio_ptr); end
        bus.in_req_val = 4'b0101;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0100) begin errors++; $display("[TB] FAIL single_next_winner: got %b expected 0100", bus.in_req_rdy); end
        bus.in_req_val = 4'b0000;
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        set_req(3, 32'hFFFF_FFFF, 32'd2);
        set_req(0, 32'd1, 32'd1);
        bus.in_req_val = 4'b1001;
        #1;
        checks++; if (bus.in_req_rdy !== 4'b1000) begin errors++; $display("[TB] FAIL bp_grant: got %b expected 1000", bus.in_req_rdy); end
        step();
        bus.in_req_val   = 4'b0001;
        bus.out_resp_rdy = 4'b0111;
        #1;
        wait_resp(ok);
        for (int j = 0; j < 5; j++) begin
            checks++; if (bus.out_resp_val !== 4'b1000) begin errors++; $display("[TB] FAIL bp_stall_val%0d: got %b expected 1000", j, bus.out_resp_val); end
            checks++; if (bus.unit_resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_unit_rdy%0d: got %b expected 0", j, bus.unit_resp_rdy); end
            checks++; if (bus.in_req_rdy !== 4'b0000) begin errors++; $display("[TB] FAIL bp_stall_in_rdy%0d: got %b expected 0000", j, bus.in_req_rdy); end
            step();
            #1;
        end
        bus.out_resp_rdy = 4'hF;
        #1;
        checks++; if (bus.unit_resp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_rdy: got %b expected 1", bus.unit_resp_rdy); end
        checks++; if (bus.out_resp_msg !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL bp_resp_msg: got %h expected fffffffe", bus.out_resp_msg); end
        step();
        #1;
        checks++; if (bus.in_req_rdy !== 4'b0001) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 0001", bus.in_req_rdy); end
        step();
        bus.in_req_val = 4'b0000;
        #1;
        wait_resp(ok);
        checks++; if (bus.out_resp_msg !== 32'd1) begin errors++; $display("[TB] FAIL bp_next_resp_msg: got %0d expected 1", bus.out_resp_msg); end
        step();
        #1;
    endtask

`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        logic [3:0]  oh;
        logic [31:0] prod;
        set_req(0, 32'd3, 32'd4);
        set_req(1, 32'd5, 32'd5);
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
        bus.in_req_val = 4'b0011;
        #1;
        checks++; if (stats_grants !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr0_grants: got %0d expected 0", stats_grants); end
        checks++; if (stats_wait_cycles !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr0_waits: got %0d expected 0", stats_wait_cycles); end
        for (int k = 0; k < 10; k++) begin
            oh   = (k % 2 == 0) ? 4'b0010 : 4'b0001;
            prod = (k % 2 == 0) ? 32'd25 : 32'd12;
            checks++; if (bus.in_req_rdy !== oh) begin errors++; $display("[TB] FAIL stats_grant%0d: got %b expected %b", k, bus.in_req_rdy, oh); end
            step();
            #1;
            wait_resp(ok);
            checks++; if (bus.out_resp_msg !== prod) begin errors++; $display("[TB] FAIL stats_resp%0d: got %0d expected %0d", k, bus.out_resp_msg, prod); end
            step();
            #1;
        end
        bus.in_req_val = 4'b0000;
        #1;
        checks++; if (stats_grants !== 32'd10) begin errors++; $display("[TB] FAIL stats_grants: got %0d expected 10", stats_grants); end
        checks++; if (stats_wait_cycles !== 32'd50) begin errors++; $display("[TB] FAIL stats_waits: got %0d expected 50", stats_wait_cycles); end
        stats_clear = 1'b1;
        bus.in_req_val = 4'b0001;
        step();
        stats_clear = 1'b0;
        bus.in_req_val = 4'b0000;
        #1;
        checks++; if (stats_grants !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr_grants: got %0d expected 0", stats_grants); end
        checks++; if (stats_wait_cycles !== 32'd0) begin errors++; $display("[TB] FAIL stats_clr_waits: got %0d expected 0", stats_wait_cycles); end
        wait_resp(ok);
        step();
        #1;
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        mul_stall        = 1'b0;
        bus.in_req_val   = '0;
        bus.in_req_msg   = '0;
        bus.out_resp_rdy = '1;
`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
        stats_clear      = 1'b0;
`endif
        #2;
        reset = 1'b0;
        test_reset();
        test_grant_freeze();
        test_reset_mid_busy();
        test_round_robin();
        test_single();
        test_backpressure();
`ifdef LAB5_MCORE_IMUL_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
